// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants for the wait-state SRAM model
package sram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LAT_W      = 4;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/sram_wait_array.sv
// rtl/sram_wait_array.sv - single-port synchronous RAM, read-first, no reset
module sram_wait_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              ck16,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge ck16) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_wait_model.sv
// rtl/sram_wait_model.sv - SRAM with req/ack handshake and LATENCY wait states
// Optional write protection below ROM_TOP via SRAM_ROM_PROTECT_EN.
module sram_wait_model
  import sram_pkg::*;
#(
  parameter int          ADDR_W  = DEF_ADDR_W,
  parameter int          DATA_W  = DEF_DATA_W,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ROM_TOP = 32'h4000
) (
  input  logic              ck16,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              wp_err
);

  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  logic [1:0]        state;
  logic [LAT_W-1:0]  cnt;
  logic              we_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_hold;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              wp_block;

  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_n_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_n_q  <= we_n;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (LATENCY == 0) begin
              state <= ST_DONE;
            end else begin
              cnt   <= LAT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_DONE: begin
          if (we_n_q) rdata_hold <= ram_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack  = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

  // In IDLE the RAM is addressed straight from the port so a zero-latency read lands in DONE.
  assign ram_addr = (state == ST_IDLE) ? addr : addr_q;
  assign rdata    = (ack && we_n_q) ? ram_q : rdata_hold;

`ifdef SRAM_ROM_PROTECT_EN
  localparam logic [ADDR_W-1:0] ROM_TOP_A = ROM_TOP[ADDR_W-1:0];
  assign wp_block = (addr_q < ROM_TOP_A);
  assign wp_err   = ack && !we_n_q && wp_block;
`else
  localparam logic [ADDR_W-1:0] unused_rom_top = ROM_TOP[ADDR_W-1:0];
  assign wp_block = 1'b0;
  assign wp_err   = 1'b0;
`endif

  assign ram_we = ack && !we_n_q && !wp_block;

  sram_wait_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .ck16  (ck16),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_sram_wait_model.sv
// tb/tb_sram_wait_model.sv - randomized bench with scoreboard for sram_wait_model
module tb_sram_wait_model;
  import sram_pkg::*;

  localparam int LAT = 2;

  logic                  ck16 = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  req, we_n, req0, we_n0;
  logic [DEF_ADDR_W-1:0] addr, addr0;
  logic [DEF_DATA_W-1:0] wdata, wdata0, rdata, rdata0;
  logic                  ack, busy, wp_err, ack0, busy0, wp_err0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DEF_DATA_W-1:0] mdl [int];
  logic [DEF_DATA_W-1:0] last_rd;
  logic [15:0]           pool [8];
  int                    k, acks;
  bit                    got;

  always #5 ck16 = ~ck16;

  sram_wait_model #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .LATENCY(LAT)) dut (
    .ck16(ck16), .reset_n(reset_n), .req(req), .we_n(we_n), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .wp_err(wp_err)
  );

  sram_wait_model #(.ADDR_W(DEF_ADDR_W), .DATA_W(DEF_DATA_W), .LATENCY(0)) dut0 (
    .ck16(ck16), .reset_n(reset_n), .req(req0), .we_n(we_n0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .wp_err(wp_err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit protected_wr(input logic wn, input logic [15:0] a);
`ifdef SRAM_ROM_PROTECT_EN
    return !wn && (a < 16'h4000);
`else
    return 1'b0;
`endif
  endfunction

  // One transaction on the LATENCY=2 instance, scored against the memory model.
  task automatic access(input logic wn, input logic [15:0] a, input logic [7:0] d);
    int  n;
    bit  seen;
    @(negedge ck16);
    req = 1'b1; we_n = wn; addr = a; wdata = d;
    @(posedge ck16);
    #1;
    req = 1'b0; we_n = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
    n = 0; seen = 0;
    while (!seen && n < LAT + 4) begin
      @(negedge ck16);
      n++;
      if (ack) seen = 1;
      else check("busy_wait", busy, 1);
    end
    check("ack_latency", n, LAT + 1);
    if (seen) begin
      check("busy_ack", busy, 1);
      check("wp_err", wp_err, protected_wr(wn, a));
      if (wn) begin
        if (mdl.exists(int'(a))) check("rd_data", rdata, mdl[int'(a)]);
        else mdl[int'(a)] = rdata;
        last_rd = mdl[int'(a)];
      end else begin
        check("wr_rdata_hold", rdata, last_rd);
        if (!protected_wr(wn, a)) mdl[int'(a)] = d;
      end
    end
    @(negedge ck16);
    check("ack_width", ack, 0);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    req = 0; we_n = 1; addr = '0; wdata = '0;
    req0 = 0; we_n0 = 1; addr0 = '0; wdata0 = '0;
    pool = '{16'h0000, 16'h0010, 16'h3FFF, 16'h4000, 16'h8000, 16'h9000, 16'hC000, 16'hFFFF};

    #1000;
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_wp_err", wp_err, 0);
    check("rst_rdata", rdata, 0);
    check("rst0_ack", ack0, 0);
    check("rst0_busy", busy0, 0);
    check("rst0_rdata", rdata0, 0);
    @(negedge ck16);
    reset_n = 1'b1;
    last_rd = '0;

    // Zero-latency instance with req held high: writes, then reads every 2nd cycle.
    req0 = 1; we_n0 = 0; addr0 = 16'h1234; wdata0 = 8'h5A;
    acks = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge ck16);
      if (ack0) begin
        acks++;
        check("z0_wr_rdata", rdata0, 0);
      end
    end
    check("z0_wr_acks", acks, 3);
    req0 = 0;
    repeat (3) @(negedge ck16);
    req0 = 1; we_n0 = 1;
    acks = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge ck16);
      check("z0_ack", ack0, i % 2);
      check("z0_busy", busy0, i % 2);
      if (ack0) begin
        acks++;
        check("z0_rdata", rdata0, 8'h5A);
      end
    end
    check("z0_rd_acks", acks, 10);
    req0 = 0;

    access(1'b1, 16'h0100, 8'h00);
    foreach (pool[i]) access(1'b0, pool[i], 8'($urandom));

    access(1'b0, 16'h8000, 8'hA5);
    access(1'b1, 16'h8000, 8'h00);

    access(1'b1, 16'h0010, 8'h00);
    access(1'b0, 16'h0010, 8'hFF);
    access(1'b1, 16'h0010, 8'h00);
    access(1'b0, 16'h4000, 8'h77);
    access(1'b1, 16'h4000, 8'h00);

    // A second req during WAIT must neither alter the response nor be queued.
    @(negedge ck16);
    req = 1; we_n = 1; addr = 16'h8000;
    @(posedge ck16);
    #1;
    we_n = 0; addr = 16'hC000; wdata = ~mdl[int'(16'hC000)];
    got = 0; k = 0;
    while (!got && k < LAT + 4) begin
      @(negedge ck16);
      k++;
      if (ack) got = 1;
    end
    req = 0;
    check("ign_latency", k, LAT + 1);
    check("ign_rdata", rdata, mdl[int'(16'h8000)]);
    last_rd = mdl[int'(16'h8000)];
    repeat (4) begin
      @(negedge ck16);
      check("ign_no_ack", ack, 0);
      check("ign_no_busy", busy, 0);
    end
    access(1'b1, 16'hC000, 8'h00);

    // Reset during WAIT of a write aborts it without committing.
    @(negedge ck16);
    req = 1; we_n = 0; addr = 16'h9000; wdata = 8'h3C;
    @(posedge ck16);
    #1;
    req = 0;
    @(negedge ck16);
    check("rmw_busy", busy, 1);
    reset_n = 0;
    #1;
    check("rmw_ack", ack, 0);
    check("rmw_busy_rst", busy, 0);
    repeat (3) @(negedge ck16);
    reset_n = 1;
    check("rmw_rdata", rdata, 0);
    last_rd = '0;
    repeat (3) begin
      @(negedge ck16);
      check("rmw_no_ack", ack, 0);
    end
    access(1'b1, 16'h9000, 8'h00);

    for (int i = 0; i < 30; i++)
      access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
